video_effects_ctrl: RTL and testbench
=====================================

Name: video_effects_ctrl

Overview:
Control-plane block for the video effects datapath. It exposes an Avalon-MM slave register bank so the CPU can write effect settings into shadow registers. Shadow settings are committed atomically to the active outputs only at a frame boundary, detected as start-of-packet on the Avalon-ST video stream, so no frame is processed with mixed settings. An optional auto-cycle sequencer steps through single effects every N frames for demo use.

Parameters:
DEFAULT_EFFECT, 8'h00, reset value of shadow and active effect word
DEFAULT_PERIOD, 16'd60, reset value of CYCLE_PERIOD (frames per auto step)
FRAME_CNT_W, 32, width of the frame counter (at most 32)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
avs_address  in  3  word address
avs_write  in  1  write strobe
avs_writedata  in  32  write data
avs_read  in  1  read strobe
avs_readdata  out  32  read data; valid 1 cycle after avs_read
st_valid  in  1  video stream valid (monitored only)
st_ready  in  1  video stream ready (monitored only)
st_sop  in  1  video stream start-of-packet
effect  out  8  active effect enables
effect_delete_rgb  out  2  active colour-delete select
effect_quantif_level  out  2  active quantisation level
effect_color_key  out  16  active chroma key, RGB565
effect_color_key_threshold  out  16  active per-component tolerance
effect_color_substitute  out  16  active substitute colour
frame_count  out  FRAME_CNT_W  frames seen since reset
irq  out  1  commit-done interrupt, level

Behaviour:
- Interface: one clock, clk. reset is asynchronous and active-low. All flops clear on reset low; no synchronous reset path.
- Register map (word address, R/W):
  - 0 CTRL: [0] COMMIT, write 1 only, self-clearing, reads 0. [1] AUTO_EN. [2] IRQ_EN. [3] PENDING, read-only.
  - 1 EFFECT: [7:0] effect, [9:8] delete_rgb, [11:10] quantif.
  - 2 KEY [15:0]; 3 THRESH [15:0]; 4 SUBST [15:0].
  - 5 CYCLE_PERIOD [15:0]. Writing 0 is treated as 1.
  - 6 FRAME_COUNT, read-only.
  - 7 STATUS: [0] DONE flag, write 1 to clear.
  - Unused read bits return 0. Writes to read-only fields are ignored.
- Reset values:
  - All outputs 0, except effect = DEFAULT_EFFECT.
  - Shadow registers equal the active values. CYCLE_PERIOD = DEFAULT_PERIOD.
  - FSM in IDLE. avs_readdata = 0.
- SOF = st_valid & st_ready & st_sop, sampled in one cycle.
- frame_count increments on each SOF and wraps modulo 2^FRAME_CNT_W.
- FSM states:
  - IDLE: a COMMIT write moves the FSM to PENDING.
  - PENDING: on SOF move to APPLY. A further COMMIT is absorbed; the FSM stays PENDING.
  - APPLY: one cycle. Copy all shadow registers to the active outputs, set DONE, return to IDLE.
  - Active outputs therefore change 1 cycle after the SOF beat; the first pixel after SOF is handled downstream, since the datapath has 1 cycle of latency.
- COMMIT written in the same cycle as a SOF does not apply at that SOF; it waits for the next SOF.
- Shadow writes during PENDING are allowed. APPLY copies the shadow contents present in the APPLY cycle.
- A COMMIT write during APPLY re-enters PENDING after APPLY completes.
- Auto-cycle (AUTO_EN=1):
  - A frame step counter counts SOFs. When it reaches CYCLE_PERIOD, the counter resets to 0 and the active effect[5:1] advances one-hot in the order 00001→00010→00100→01000→10000→00001.
  - If no bit in effect[5:1] is set, it starts at 00001.
  - effect[0], effect[7:6] and all non-effect active fields are kept.
  - If APPLY and an auto step fall on the same SOF, the manual commit wins and the step counter resets to 0.
  - Clearing AUTO_EN freezes the active values and resets the step counter.
- irq = DONE & IRQ_EN.
- If reset is asserted mid-PENDING, the pending commit is lost.

Optional Feature:
- Macro: VFX_CTRL_IRQ_EN.
- Defined: DONE flag, IRQ_EN and the irq output behave as above.
- Undefined: irq is tied to 0, STATUS reads 0, CTRL[2] reads 0, writes to them are ignored, and no DONE flop is built.

Decomposition:
- Package vfx_ctrl_pkg holds:
  - Register address constants REG_CTRL..REG_STATUS.
  - CTRL bit indices.
  - FSM state encoding: IDLE, PENDING, APPLY.
  - One-hot auto-cycle constants.
- One sub-module, vfx_ctrl_autocycle, contains the step counter and the one-hot rotation logic. Its inputs are SOF, AUTO_EN, period, current effect and an apply-override signal; its outputs are the next effect value and a step strobe.

Test Plan:
- Reset release, then read addr 1 → 0x000000{DEFAULT_EFFECT}; read addr 5 → 60; all outputs 0 except effect.
- Write EFFECT=0x0A4, KEY=0x07E0, then COMMIT → outputs unchanged and PENDING=1. After the next SOF: effect=0xA4, delete_rgb=0, quantif=0, key=0x07E0 one cycle later, PENDING=0.
- COMMIT in the same cycle as a SOF → no change at that SOF. Outputs update only after the second SOF.
- Shadow EFFECT rewritten to 0x10 while PENDING → the active value after SOF is 0x10.
- AUTO_EN=1, CYCLE_PERIOD=2, effect=0x03 → after 2 SOFs effect=0x05, after 4 SOFs 0x09; SOF with st_ready=0 does not count.
- IRQ_EN=1, commit plus SOF → irq=1. Write STATUS=1 → irq=0 next cycle. With VFX_CTRL_IRQ_EN undefined, irq stays 0 throughout.

Source files
------------

// File: rtl/vfx_ctrl_pkg.sv
// Shared constants for the video effects control block: register map, CTRL bits,
// commit FSM encoding and the auto-cycle one-hot rotation helper.
package vfx_ctrl_pkg;

    localparam logic [2:0] REG_CTRL        = 3'd0;
    localparam logic [2:0] REG_EFFECT      = 3'd1;
    localparam logic [2:0] REG_KEY         = 3'd2;
    localparam logic [2:0] REG_THRESH      = 3'd3;
    localparam logic [2:0] REG_SUBST       = 3'd4;
    localparam logic [2:0] REG_PERIOD      = 3'd5;
    localparam logic [2:0] REG_FRAME_COUNT = 3'd6;
    localparam logic [2:0] REG_STATUS      = 3'd7;

    localparam int CTRL_COMMIT  = 0;
    localparam int CTRL_AUTO_EN = 1;
    localparam int CTRL_IRQ_EN  = 2;
    localparam int CTRL_PENDING = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        APPLY   = 2'd2
    } state_t;

    localparam int         AUTO_W     = 5;
    localparam logic [4:0] AUTO_FIRST = 5'b00001;

    // Rotate the effect[5:1] group; an empty group restarts at the first effect.
    function automatic logic [AUTO_W-1:0] auto_rotate(input logic [AUTO_W-1:0] cur);
        if (cur == '0)
            return AUTO_FIRST;
        return {cur[AUTO_W-2:0], cur[AUTO_W-1]};
    endfunction

endpackage

// File: rtl/vfx_ctrl_autocycle.sv
// Demo sequencer: counts frames and advances effect[5:1] one-hot every period frames.
// step fires combinationally on the qualifying SOF; a manual apply on that SOF suppresses it.
module vfx_ctrl_autocycle
    import vfx_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        sof,
    input  logic        auto_en,
    input  logic [15:0] period,
    input  logic [7:0]  effect_in,
    input  logic        apply_override,
    output logic [7:0]  effect_next,
    output logic        step
);

    logic [15:0] step_cnt;
    logic [15:0] period_eff;
    logic        last_frame;

    assign period_eff  = (period == 16'd0) ? 16'd1 : period;
    assign last_frame  = ({1'b0, step_cnt} + 17'd1) >= {1'b0, period_eff};
    assign step        = auto_en & sof & ~apply_override & last_frame;
    assign effect_next = {effect_in[7:6], auto_rotate(effect_in[5:1]), effect_in[0]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            step_cnt <= 16'd0;
        else if (!auto_en || (sof && (apply_override || last_frame)))
            step_cnt <= 16'd0;
        else if (sof)
            step_cnt <= step_cnt + 16'd1;
    end

endmodule

// File: rtl/video_effects_ctrl.sv
// Avalon-MM shadow register bank committed atomically to the effect outputs at frame start.
// Optional commit-done interrupt is built only when VFX_CTRL_IRQ_EN is defined.
module video_effects_ctrl
    import vfx_ctrl_pkg::*;
#(
    parameter logic [7:0]  DEFAULT_EFFECT = 8'h00,
    parameter logic [15:0] DEFAULT_PERIOD = 16'd60,
    parameter int          FRAME_CNT_W    = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [2:0]             avs_address,
    input  logic                   avs_write,
    input  logic [31:0]            avs_writedata,
    input  logic                   avs_read,
    output logic [31:0]            avs_readdata,
    input  logic                   st_valid,
    input  logic                   st_ready,
    input  logic                   st_sop,
    output logic [7:0]             effect,
    output logic [1:0]             effect_delete_rgb,
    output logic [1:0]             effect_quantif_level,
    output logic [15:0]            effect_color_key,
    output logic [15:0]            effect_color_key_threshold,
    output logic [15:0]            effect_color_substitute,
    output logic [FRAME_CNT_W-1:0] frame_count,
    output logic                   irq
);

    state_t      state, state_nxt;
    logic        sof, commit, apply, step;
    logic        auto_en, irq_en_rd, done_rd;
    logic [7:0]  sh_effect, auto_effect;
    logic [1:0]  sh_delete, sh_quant;
    logic [15:0] sh_key, sh_thresh, sh_subst, period;
    logic [31:0] rd_mux;
    logic        unused_wdata;

    assign sof          = st_valid & st_ready & st_sop;
    assign commit       = avs_write && (avs_address == REG_CTRL) && avs_writedata[CTRL_COMMIT];
    assign apply        = (state == APPLY);
    assign unused_wdata = ^avs_writedata[31:16];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // A commit landing during APPLY is kept by re-entering PENDING afterwards.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (commit) state_nxt = PENDING;
            PENDING: if (sof)    state_nxt = APPLY;
            APPLY:   state_nxt = commit ? PENDING : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sh_effect <= DEFAULT_EFFECT;
            sh_delete <= 2'd0;
            sh_quant  <= 2'd0;
            sh_key    <= 16'd0;
            sh_thresh <= 16'd0;
            sh_subst  <= 16'd0;
            period    <= DEFAULT_PERIOD;
            auto_en   <= 1'b0;
        end else if (avs_write) begin
            case (avs_address)
                REG_CTRL:   auto_en <= avs_writedata[CTRL_AUTO_EN];
                REG_EFFECT: begin
                    sh_effect <= avs_writedata[7:0];
                    sh_delete <= avs_writedata[9:8];
                    sh_quant  <= avs_writedata[11:10];
                end
                REG_KEY:    sh_key    <= avs_writedata[15:0];
                REG_THRESH: sh_thresh <= avs_writedata[15:0];
                REG_SUBST:  sh_subst  <= avs_writedata[15:0];
                REG_PERIOD: period    <= (avs_writedata[15:0] == 16'd0) ? 16'd1 : avs_writedata[15:0];
                default:    ;
            endcase
        end
    end

    vfx_ctrl_autocycle u_autocycle (
        .clk            (clk),
        .reset          (reset),
        .sof            (sof),
        .auto_en        (auto_en),
        .period         (period),
        .effect_in      (effect),
        .apply_override (state == PENDING),
        .effect_next    (auto_effect),
        .step           (step)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            effect                     <= DEFAULT_EFFECT;
            effect_delete_rgb          <= 2'd0;
            effect_quantif_level       <= 2'd0;
            effect_color_key           <= 16'd0;
            effect_color_key_threshold <= 16'd0;
            effect_color_substitute    <= 16'd0;
        end else if (apply) begin
            effect                     <= sh_effect;
            effect_delete_rgb          <= sh_delete;
            effect_quantif_level       <= sh_quant;
            effect_color_key           <= sh_key;
            effect_color_key_threshold <= sh_thresh;
            effect_color_substitute    <= sh_subst;
        end else if (step) begin
            effect <= auto_effect;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            frame_count <= '0;
        else if (sof)
            frame_count <= frame_count + 1'b1;
    end

`ifdef VFX_CTRL_IRQ_EN
    logic irq_en, done;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            irq_en <= 1'b0;
            done   <= 1'b0;
        end else begin
            if (avs_write && avs_address == REG_CTRL)
                irq_en <= avs_writedata[CTRL_IRQ_EN];
            // Setting on APPLY takes priority over a simultaneous clear.
            if (apply)
                done <= 1'b1;
            else if (avs_write && avs_address == REG_STATUS && avs_writedata[0])
                done <= 1'b0;
        end
    end

    assign irq       = done & irq_en;
    assign irq_en_rd = irq_en;
    assign done_rd   = done;
`else
    assign irq       = 1'b0;
    assign irq_en_rd = 1'b0;
    assign done_rd   = 1'b0;
`endif

    always_comb begin
        rd_mux = 32'd0;
        case (avs_address)
            REG_CTRL: begin
                rd_mux[CTRL_AUTO_EN] = auto_en;
                rd_mux[CTRL_IRQ_EN]  = irq_en_rd;
                rd_mux[CTRL_PENDING] = (state == PENDING);
            end
            REG_EFFECT:      rd_mux[11:0] = {sh_quant, sh_delete, sh_effect};
            REG_KEY:         rd_mux[15:0] = sh_key;
            REG_THRESH:      rd_mux[15:0] = sh_thresh;
            REG_SUBST:       rd_mux[15:0] = sh_subst;
            REG_PERIOD:      rd_mux[15:0] = period;
            REG_FRAME_COUNT: rd_mux       = 32'(frame_count);
            REG_STATUS:      rd_mux[0]    = done_rd;
            default:         rd_mux       = 32'd0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            avs_readdata <= 32'd0;
        else if (avs_read)
            avs_readdata <= rd_mux;
    end

endmodule

// File: tb/tb_video_effects_ctrl.sv
// Directed bench for video_effects_ctrl: register table plus commit, auto-cycle and irq sequences.
module tb_video_effects_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [2:0]  avs_address = 3'd0;
    logic        avs_write = 1'b0;
    logic [31:0] avs_writedata = 32'd0;
    logic        avs_read = 1'b0;
    logic [31:0] avs_readdata;
    logic        st_valid = 1'b0, st_ready = 1'b0, st_sop = 1'b0;
    logic [7:0]  effect;
    logic [1:0]  effect_delete_rgb, effect_quantif_level;
    logic [15:0] effect_color_key, effect_color_key_threshold, effect_color_substitute;
    logic [31:0] frame_count;
    logic        irq;

    video_effects_ctrl dut (
        .clk                        (clk),
        .reset                      (reset),
        .avs_address                (avs_address),
        .avs_write                  (avs_write),
        .avs_writedata              (avs_writedata),
        .avs_read                   (avs_read),
        .avs_readdata               (avs_readdata),
        .st_valid                   (st_valid),
        .st_ready                   (st_ready),
        .st_sop                     (st_sop),
        .effect                     (effect),
        .effect_delete_rgb          (effect_delete_rgb),
        .effect_quantif_level       (effect_quantif_level),
        .effect_color_key           (effect_color_key),
        .effect_color_key_threshold (effect_color_key_threshold),
        .effect_color_substitute    (effect_color_substitute),
        .frame_count                (frame_count),
        .irq                        (irq)
    );

    always #5 clk = ~clk;

`ifdef VFX_CTRL_IRQ_EN
    localparam logic IRQ_BUILT = 1'b1;
`else
    localparam logic IRQ_BUILT = 1'b0;
`endif

    typedef struct {
        logic        wr;
        logic [2:0]  addr;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;

    vec_t        vecs[$];
    int          n_checks = 0;
    int          n_pass = 0;
    int          exp_frames = 0;
    logic [31:0] rdata;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    task automatic add(input logic wr, input logic [2:0] a, input logic [31:0] d, input logic [31:0] e);
        vec_t v;
        v.wr = wr; v.addr = a; v.data = d; v.exp = e;
        vecs.push_back(v);
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        avs_address = a; avs_writedata = d; avs_write = 1'b1;
        @(negedge clk);
        avs_write = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] d);
        @(negedge clk);
        avs_address = a; avs_read = 1'b1;
        @(negedge clk);
        avs_read = 1'b0;
        d = avs_readdata;
    endtask

    task automatic sof(input logic rdy);
        @(negedge clk);
        st_valid = 1'b1; st_ready = rdy; st_sop = 1'b1;
        @(negedge clk);
        st_valid = 1'b0; st_ready = 1'b0; st_sop = 1'b0;
        if (rdy) exp_frames++;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        idle(2);
        check("reset_effect", {24'd0, effect}, 32'h00);
        check("reset_key", {16'd0, effect_color_key}, 32'h0);
        check("reset_frames", frame_count, 32'd0);
        check("reset_irq", {31'd0, irq}, 32'd0);
        check("reset_rdata", avs_readdata, 32'd0);
        reset = 1'b1;
        idle(2);

        add(0, 3'd1, 0, 32'h0);          add(0, 3'd5, 0, 32'd60);
        add(0, 3'd0, 0, 32'h0);          add(0, 3'd6, 0, 32'h0);
        add(0, 3'd7, 0, 32'h0);
        add(1, 3'd2, 32'h1234_07E0, 0);  add(0, 3'd2, 0, 32'h07E0);
        add(1, 3'd3, 32'hFFFF_0842, 0);  add(0, 3'd3, 0, 32'h0842);
        add(1, 3'd4, 32'h0000_F800, 0);  add(0, 3'd4, 0, 32'hF800);
        add(1, 3'd1, 32'hFFFF_F0A4, 0);  add(0, 3'd1, 0, 32'h0A4);
        add(1, 3'd5, 32'd0, 0);          add(0, 3'd5, 0, 32'd1);
        add(1, 3'd5, 32'd60, 0);         add(0, 3'd5, 0, 32'd60);
        add(1, 3'd6, 32'd5, 0);          add(0, 3'd6, 0, 32'd0);
        add(1, 3'd0, 32'd2, 0);          add(0, 3'd0, 0, 32'd2);
        add(1, 3'd0, 32'd0, 0);          add(0, 3'd0, 0, 32'd0);
        add(1, 3'd7, 32'd1, 0);          add(0, 3'd7, 0, 32'd0);
        foreach (vecs[i]) begin
            if (vecs[i].wr) begin
                wr(vecs[i].addr, vecs[i].data);
            end else begin
                rd(vecs[i].addr, rdata);
                check($sformatf("regtab[%0d] addr%0d", i, vecs[i].addr), rdata, vecs[i].exp);
            end
        end
        check("shadow_not_live", {16'd0, effect_color_key}, 32'h0);

        // Basic commit: outputs hold until the next SOF
        wr(3'd0, 32'd1);
        check("commit_hold_effect", {24'd0, effect}, 32'h00);
        rd(3'd0, rdata);
        check("commit_pending", rdata, 32'h8);
        sof(1'b1);
        idle(2);
        check("apply_effect", {24'd0, effect}, 32'hA4);
        check("apply_delete", {30'd0, effect_delete_rgb}, 32'd0);
        check("apply_quant", {30'd0, effect_quantif_level}, 32'd0);
        check("apply_key", {16'd0, effect_color_key}, 32'h07E0);
        check("apply_thresh", {16'd0, effect_color_key_threshold}, 32'h0842);
        check("apply_subst", {16'd0, effect_color_substitute}, 32'hF800);
        rd(3'd0, rdata);
        check("pending_cleared", rdata, 32'h0);
        rd(3'd7, rdata);
        check("done_flag", rdata, {31'd0, IRQ_BUILT});
        wr(3'd7, 32'd1);

        // COMMIT in the same cycle as SOF waits for the following SOF
        wr(3'd1, 32'h021);
        @(negedge clk);
        avs_address = 3'd0; avs_writedata = 32'd1; avs_write = 1'b1;
        st_valid = 1'b1; st_ready = 1'b1; st_sop = 1'b1;
        @(negedge clk);
        avs_write = 1'b0; st_valid = 1'b0; st_ready = 1'b0; st_sop = 1'b0;
        exp_frames++;
        idle(3);
        check("same_cycle_hold", {24'd0, effect}, 32'hA4);
        rd(3'd0, rdata);
        check("same_cycle_pending", rdata, 32'h8);
        sof(1'b1);
        idle(2);
        check("second_sof_apply", {24'd0, effect}, 32'h21);

        // Shadow rewritten while pending
        wr(3'd1, 32'h055);
        wr(3'd0, 32'd1);
        wr(3'd1, 32'hD10);
        sof(1'b1);
        idle(2);
        check("rewrite_effect", {24'd0, effect}, 32'h10);
        check("rewrite_delete", {30'd0, effect_delete_rgb}, 32'd1);
        check("rewrite_quant", {30'd0, effect_quantif_level}, 32'd3);
        sof(1'b0);
        check("frames_no_ready", frame_count, exp_frames);

        // Auto-cycle with period 2; stalled SOFs are ignored
        wr(3'd1, 32'h003);
        wr(3'd0, 32'd1);
        sof(1'b1);
        idle(2);
        check("auto_base", {24'd0, effect}, 32'h03);
        wr(3'd5, 32'd2);
        wr(3'd0, 32'd2);
        sof(1'b1);
        check("auto_sof1", {24'd0, effect}, 32'h03);
        sof(1'b0);
        sof(1'b1);
        check("auto_step1", {24'd0, effect}, 32'h05);
        sof(1'b1);
        sof(1'b1);
        check("auto_step2", {24'd0, effect}, 32'h09);
        wr(3'd0, 32'd0);
        sof(1'b1);
        sof(1'b1);
        check("auto_frozen", {24'd0, effect}, 32'h09);
        check("frame_count", frame_count, exp_frames);
        rd(3'd6, rdata);
        check("frame_count_reg", rdata, exp_frames);

        // Commit-done interrupt
        wr(3'd7, 32'd1);
        wr(3'd0, 32'd4);
        rd(3'd0, rdata);
        check("irq_en_readback", rdata, IRQ_BUILT ? 32'h4 : 32'h0);
        check("irq_idle", {31'd0, irq}, 32'd0);
        wr(3'd1, 32'h040);
        wr(3'd0, 32'd5);
        sof(1'b1);
        idle(2);
        check("irq_effect", {24'd0, effect}, 32'h40);
        check("irq_raised", {31'd0, irq}, {31'd0, IRQ_BUILT});
        wr(3'd7, 32'd1);
        check("irq_cleared", {31'd0, irq}, 32'd0);

        // Reset during PENDING drops the commit
        wr(3'd1, 32'h0FF);
        wr(3'd0, 32'd1);
        rd(3'd0, rdata);
        check("pre_reset_pending", rdata, 32'h8);
        @(negedge clk);
        reset = 1'b0;
        idle(2);
        check("mid_reset_effect", {24'd0, effect}, 32'h00);
        check("mid_reset_frames", frame_count, 32'd0);
        check("mid_reset_rdata", avs_readdata, 32'd0);
        reset = 1'b1;
        idle(2);
        sof(1'b1);
        idle(2);
        check("lost_commit_effect", {24'd0, effect}, 32'h00);
        rd(3'd0, rdata);
        check("lost_commit_ctrl", rdata, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
